rr_arb_1hot: RTL and testbench
==============================

Name: rr_arb_1hot

Overview:
Round-robin arbiter that produces the one-hot select consumed by the team's one-hot mux blocks. It sits upstream of a Mux1hot instance, so gnt drives sel directly. Each grant is held until the owner signals completion, drops its request, or exceeds a hold limit. Priority then rotates to the requester after the owner, giving starvation-free sharing of one datapath among N sources.

Parameters:
N, 8, number of requesters; width of req/gnt; legal range 2..32
IDX_W, $clog2(N), width of gnt_idx; derived, not to be overridden
MAX_HOLD, 0, maximum consecutive cycles of one grant; 0 disables the limit

Ports:
clk  input  1  single clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
req  input  N  request vector; req[i]=1 means source i wants the datapath
done  input  1  owner finished its transaction; sampled only in GRANT
gnt  output  N  registered grant; either all-zero or exactly one bit set; feeds Mux1hot sel
gnt_valid  output  1  OR of gnt, registered
gnt_idx  output  IDX_W  binary index of the set gnt bit; 0 when gnt_valid=0
timeout  output  1  one-cycle pulse on the edge a grant is force-released by MAX_HOLD

Behaviour:
- Reset (asynchronous, immediate): gnt=0, gnt_valid=0, gnt_idx=0, timeout=0, ptr=0, hold_cnt=0, state=IDLE. A reset asserted mid-grant clears gnt with no clock edge.
- Internal state: ptr (IDX_W bits) is the highest-priority index; owner is the index of the current grant; hold_cnt counts cycles of the current grant.
- Winner function: the first i with req[i]=1, scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1 (mod N). It is combinational from the current req and ptr.
- IDLE:
  - If req is non-zero, on the next edge gnt=onehot(winner), gnt_idx=winner, gnt_valid=1, hold_cnt=0, state=GRANT.
  - The latency from req to gnt is 1 cycle.
  - done is ignored in IDLE.
- GRANT:
  - gnt is held stable and hold_cnt increments each cycle, saturating.
  - The release condition is any of: done=1; req[owner]=0; MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1.
- On a release edge:
  - ptr is set to (owner+1) mod N; wrap from N-1 to 0.
  - The winner is recomputed from the current req, using the new ptr value.
  - If the recomputed winner exists, gnt switches directly to it with no idle bubble, hold_cnt=0, and state stays GRANT.
  - The previous owner may win again only if it is the sole requester.
  - If no requester remains, gnt=0 and state=IDLE.
- timeout=1 for exactly the cycle following a release caused solely by MAX_HOLD. If done=1 or req[owner]=0 is also true on that edge, timeout stays 0.
- New requests arriving during GRANT never preempt the owner.
- Invariant: $countones(gnt)<=1 at all times. The bench checks this with an assertion.
- All outputs are registered; there is no combinational path from req or done to gnt.

Test Plan:
- Reset/idle: rst=1 then 0 with req=0 for 10 cycles -> gnt=0, gnt_valid=0, gnt_idx=0, timeout=0 throughout. Assert rst mid-grant -> gnt=0 before the next clk edge.
- Single hold: N=8, req=8'h08 from cycle 0, done pulsed at cycle 5 -> gnt=8'h08, gnt_idx=3 from cycle 1 through 5; gnt=0 at cycle 6; ptr=4.
- Rotation: req=8'hFF held, done=1 every GRANT cycle -> gnt_idx sequence 0,1,2,3,4,5,6,7,0,1 on consecutive cycles with no bubbles.
- Wrap/priority: after a grant to 7 releases, req=8'h03 -> next gnt=8'h01. After that release, with req=8'h03 still held -> gnt=8'h02.
- Timeout: MAX_HOLD=4, req=8'h24 held, done=0 -> gnt=8'h04 for 4 cycles, then timeout=1 for one cycle coincident with gnt=8'h20. After 4 more cycles gnt returns to 8'h04.
- Drop/simultaneous: owner 2 drops req[2] on the same edge that req[6] rises, with ptr=0 -> gnt=8'h40 next cycle, timeout=0. Owner drops with no other req -> gnt=0, IDLE.

Source files
------------

// File: rtl/rr_arb_1hot.sv
// rtl/rr_arb_1hot.sv - round-robin arbiter with held one-hot grant for Mux1hot select
//
// Ports:
//   clk        in   clock; all state updates on the rising edge
//   rst        in   asynchronous, active-high reset
//   req        in   [N]      request vector, one bit per source
//   done       in   owner finished its transaction (looked at only while granting)
//   gnt        out  [N]      registered one-hot (or zero) grant, drives Mux1hot sel
//   gnt_valid  out  registered OR of gnt
//   gnt_idx    out  [IDX_W]  binary index of the granted source, 0 when idle
//   timeout    out  one-cycle pulse after a grant is force-released by MAX_HOLD

module rr_arb_1hot #(
  parameter int N        = 8,
  parameter int IDX_W    = $clog2(N),
  parameter int MAX_HOLD = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic [N-1:0]     gnt,
  output logic             gnt_valid,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             timeout
);

  // Hold counter only has to reach MAX_HOLD-1; it saturates at all-ones.
  localparam int HC_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD);
  localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N - 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t           state_q;
  logic [IDX_W-1:0] ptr_q;
  logic [HC_W-1:0]  hold_cnt_q;
  logic [N-1:0]     gnt_q;
  logic             gnt_valid_q;
  logic [IDX_W-1:0] gnt_idx_q;
  logic             timeout_q;

  // Returns {found, index} of the first requester at or after base,
  // wrapping modulo N. The request vector is rotated so that base lands on
  // bit 0; the lowest set bit of the rotated vector is then the winner.
  function automatic logic [IDX_W:0] rr_pick(input logic [N-1:0] r,
                                             input logic [IDX_W-1:0] base);
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IDX_W:0] res;
    int             sum;
    dbl = {r, r} >> base;
    rot = dbl[N-1:0];
    res = '0;
    sum = 0;
    // Descending scan so the last hit kept is the lowest rotated position.
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        sum = int'(base) + i;
        if (sum >= N) sum = sum - N;
        res = {1'b1, sum[IDX_W-1:0]};
      end
    end
    return res;
  endfunction

  function automatic logic [N-1:0] to_onehot(input logic [IDX_W-1:0] idx);
    return N'(1) << idx;
  endfunction

  logic [IDX_W-1:0] owner;
  logic             owner_req;
  logic [IDX_W-1:0] next_ptr;
  logic             hold_hit;
  logic             release_now;
  logic [IDX_W:0]   pick_idle;
  logic [IDX_W:0]   pick_rel;

  always_comb begin
    owner       = gnt_idx_q;
    owner_req   = req[owner];
    next_ptr    = (owner == LAST_IDX) ? '0 : owner + IDX_W'(1);
    hold_hit    = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);
    release_now = (state_q == S_GRANT) && (done || !owner_req || hold_hit);
    // Idle arbitration uses the stored pointer; a release arbitrates with the
    // pointer it is about to install, so the handover has no idle bubble.
    pick_idle   = rr_pick(req, ptr_q);
    pick_rel    = rr_pick(req, next_ptr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      hold_cnt_q  <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_idx_q   <= '0;
      timeout_q   <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pick_idle[IDX_W]) begin
            gnt_q       <= to_onehot(pick_idle[IDX_W-1:0]);
            gnt_idx_q   <= pick_idle[IDX_W-1:0];
            gnt_valid_q <= 1'b1;
            hold_cnt_q  <= '0;
            state_q     <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (release_now) begin
            ptr_q      <= next_ptr;
            hold_cnt_q <= '0;
            // Only a pure hold-limit release is reported.
            timeout_q  <= hold_hit && !done && owner_req;
            if (pick_rel[IDX_W]) begin
              gnt_q     <= to_onehot(pick_rel[IDX_W-1:0]);
              gnt_idx_q <= pick_rel[IDX_W-1:0];
            end else begin
              gnt_q       <= '0;
              gnt_idx_q   <= '0;
              gnt_valid_q <= 1'b0;
              state_q     <= S_IDLE;
            end
          end else if (hold_cnt_q != '1) begin
            hold_cnt_q <= hold_cnt_q + HC_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_idx   = gnt_idx_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arb_1hot.sv
// tb/tb_rr_arb_1hot.sv - bench for rr_arb_1hot: directed literals plus random vs reference model

module tb_rr_arb_1hot;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic         done;

  logic [N-1:0] gnt0, gnt1;
  logic         gv0, gv1;
  logic [2:0]   gi0, gi1;
  logic         to0, to1;

  int n_checks = 0;
  int n_pass   = 0;

  // Instance 0: no hold limit. Instance 1: MAX_HOLD=4. Same stimulus.
  rr_arb_1hot #(.N(N), .MAX_HOLD(0)) dut0 (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt0), .gnt_valid(gv0), .gnt_idx(gi0), .timeout(to0)
  );

  rr_arb_1hot #(.N(N), .MAX_HOLD(4)) dut1 (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt1), .gnt_valid(gv1), .gnt_idx(gi1), .timeout(to1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: owner (-1 = none), priority pointer, age = cycles the
  // current grant has been visible, and the pending timeout flag.
  int m_owner[2] = '{-1, -1};
  int m_ptr[2]   = '{0, 0};
  int m_age[2]   = '{0, 0};
  int m_to[2]    = '{0, 0};
  int m_hold[2]  = '{0, 4};

  function automatic int scan(input logic [N-1:0] r, input int p);
    int j;
    for (int k = 0; k < N; k++) begin
      j = (p + k) % N;
      if (r[j] == 1'b1) return j;
    end
    return -1;
  endfunction

  task automatic model_edge(input int u, input logic [N-1:0] r, input logic d);
    int  w;
    bit  lim;
    m_to[u] = 0;
    if (m_owner[u] < 0) begin
      w = scan(r, m_ptr[u]);
      if (w >= 0) begin
        m_owner[u] = w;
        m_age[u]   = 1;
      end
    end else begin
      lim = (m_hold[u] != 0) && (m_age[u] == m_hold[u]);
      if (d || !r[m_owner[u]] || lim) begin
        m_to[u]    = (lim && !d && r[m_owner[u]]) ? 1 : 0;
        m_ptr[u]   = (m_owner[u] + 1) % N;
        w          = scan(r, m_ptr[u]);
        m_owner[u] = w;
        m_age[u]   = (w >= 0) ? 1 : 0;
      end else begin
        m_age[u]++;
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int u = 0; u < 2; u++) begin
        m_owner[u] = -1; m_ptr[u] = 0; m_age[u] = 0; m_to[u] = 0;
      end
    end else begin
      model_edge(0, req, done);
      model_edge(1, req, done);
    end
  end

  task automatic cmp_inst(input int u, input logic [N-1:0] g, input logic v,
                          input logic [2:0] gi, input logic t);
    int eg, ev, ei;
    eg = (m_owner[u] >= 0) ? (1 << m_owner[u]) : 0;
    ev = (m_owner[u] >= 0) ? 1 : 0;
    ei = (m_owner[u] >= 0) ? m_owner[u] : 0;
    chk($sformatf("model%0d.gnt", u), int'(g), eg);
    chk($sformatf("model%0d.gnt_valid", u), int'(v), ev);
    chk($sformatf("model%0d.gnt_idx", u), int'(gi), ei);
    chk($sformatf("model%0d.timeout", u), int'(t), m_to[u]);
  endtask

  always @(negedge clk) begin
    a_onehot0: assert ($countones(gnt0) <= 1 && $countones(gnt1) <= 1)
      else $error("FAIL onehot0: gnt0=%0h gnt1=%0h", gnt0, gnt1);
    chk("onehot0", int'($countones(gnt0) <= 1 && $countones(gnt1) <= 1), 1);
    cmp_inst(0, gnt0, gv0, gi0, to0);
    cmp_inst(1, gnt1, gv1, gi1, to1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst  = 1'b1;
    req  = '0;
    done = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Idle after reset: all outputs zero.
    for (int c = 0; c < 10; c++) begin
      step();
      chk("idle.gnt", int'(gnt0), 0);
      chk("idle.gnt_valid", int'(gv0), 0);
      chk("idle.gnt_idx", int'(gi0), 0);
      chk("idle.timeout", int'(to0), 0);
    end

    // Rotation with done every cycle: 0..7,0,1 with no bubbles.
    req = 8'hFF; done = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("rot.gnt_idx", int'(gi0), k % 8);
      chk("rot.gnt_valid", int'(gv0), 1);
    end
    req = '0; done = 1'b0;
    step();
    chk("rot.end", int'(gnt0), 0);

    // Single hold on source 3 for five cycles, then done with request dropped.
    req = 8'h08;
    for (int c = 1; c <= 5; c++) begin
      step();
      chk("hold.gnt", int'(gnt0), 8'h08);
      chk("hold.gnt_idx", int'(gi0), 3);
    end
    req = '0; done = 1'b1;
    step();
    chk("hold.release", int'(gnt0), 0);
    chk("hold.release_valid", int'(gv0), 0);
    // Pointer must now be 4.
    req = 8'hFF; done = 1'b0;
    step();
    chk("hold.ptr4", int'(gi0), 4);
    req = '0;
    step();

    // Wrap from 7: next grant goes to 0, then 1.
    req = 8'h80;
    step();
    chk("wrap.gnt7", int'(gnt0), 8'h80);
    req = 8'h03;
    step();
    chk("wrap.gnt0", int'(gnt0), 8'h01);
    done = 1'b1;
    step();
    chk("wrap.gnt1", int'(gnt0), 8'h02);
    req = '0; done = 1'b0;
    step();
    chk("wrap.idle", int'(gnt0), 0);

    // Owner 2 drops while 6 rises, with ptr=0.
    req = 8'h80;
    step();
    req = 8'h04;
    step();
    chk("drop.gnt2", int'(gnt0), 8'h04);
    req = 8'h40;
    step();
    chk("drop.gnt6", int'(gnt0), 8'h40);
    chk("drop.timeout", int'(to0), 0);
    req = '0;
    step();
    chk("drop.idle_gnt", int'(gnt0), 0);
    chk("drop.idle_valid", int'(gv0), 0);
    chk("drop.idle_idx", int'(gi0), 0);

    // Hold limit on instance 1: 4 cycles of 2, then 5 with timeout, then back.
    req = 8'h24;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c <= 4 || c == 9) chk("tmo.gnt", int'(gnt1), 8'h04);
      else                  chk("tmo.gnt", int'(gnt1), 8'h20);
      chk("tmo.timeout", int'(to1), (c == 5 || c == 9) ? 1 : 0);
    end
    chk("tmo.nolimit", int'(gnt0), 8'h04);
    req = '0;
    step();

    // Asynchronous reset in the middle of a grant.
    req = 8'h01;
    step();
    chk("rst.pre", int'(gnt0), 8'h01);
    #2 rst = 1'b1;
    #1;
    chk("rst.async_gnt0", int'(gnt0), 0);
    chk("rst.async_gnt1", int'(gnt1), 0);
    chk("rst.async_valid", int'(gv0), 0);
    step();
    rst = 1'b0;
    req = '0;

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      step();
      if (rst) rst = 1'b0;
      case ($urandom_range(3))
        0: req = N'($urandom);
        1: req = N'($urandom & $urandom);
        2: req = req;
        default: req = ($urandom_range(3) == 0) ? '0 : (N'(1) << $urandom_range(N - 1));
      endcase
      done = ($urandom_range(4) == 0);
      if ($urandom_range(299) == 0) rst = 1'b1;
    end
    rst = 1'b0; req = '0; done = 1'b0;
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
